// File: rtl/simpleproc_mem_arbiter.sv
// simpleproc_mem_arbiter: round-robin arbiter sharing one single-port memory
// between the simpleproc core (port 0) and the loader/debug port (port 1).
// One access at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
module simpleproc_mem_arbiter #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic [DW-1:0] rdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic [DW-1:0] rdata1,
    output logic          ack1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // Counter preload: remaining WAIT cycles after ISSUE before read data is valid
    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          last_q;
    logic          gid_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic [1:0]    cnt_q;
    logic          any_req;
    logic          win;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) win = ~last_q;
        else              win = req1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; requests are only evaluated in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command register, arbitration history, latency counter and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b1;
            gid_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gid_q   <= win;
                        last_q  <= win;
                        we_q    <= win ? we1 : we0;
                        addr_q  <= win ? addr1 : addr0;
                        wdata_q <= win ? wdata1 : wdata0;
                    end
                end
                ISSUE: cnt_q <= CNT_INIT;
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else if (!we_q) begin
                        if (gid_q) rdata1_q <= mem_rdata;
                        else       rdata0_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        mem_en    = (state_q == ISSUE);
        busy      = (state_q != IDLE);
        ack0      = (state_q == DONE) && !gid_q;
        ack1      = (state_q == DONE) && gid_q;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
        grant_id  = gid_q;
    end

endmodule

// File: tb/tb_simpleproc_mem_arbiter.sv
// Bench for simpleproc_mem_arbiter: four instances with MEM_LAT = 1..4, each
// with its own latency-accurate memory model, checked every cycle against a
// transaction-timeline reference model.
module tb_simpleproc_mem_arbiter;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       req_s  [NI][2];
    logic       we_s   [NI][2];
    logic [7:0] addr_s [NI][2];
    logic [7:0] wdat_s [NI][2];
    logic [7:0] rd     [NI][2];
    logic       ak     [NI][2];
    logic       men [NI], mwe [NI], bsy [NI], gid [NI];
    logic [7:0] madr [NI], mwd [NI], mrd [NI];

    int n_err = 0;
    int n_chk = 0;
    int t = 0;

    // Reference model state
    bit         last_m   [NI];
    int         free_at  [NI];
    bit         have_cur [NI];
    int         cur_g    [NI];
    bit         cur_p    [NI];
    bit         cur_we   [NI];
    logic [7:0] cur_a    [NI], cur_d [NI], cur_rv [NI];
    logic [7:0] exp_rd   [NI][2];
    logic [7:0] ref_mem  [NI][256];
    bit         pend     [NI][2];
    int         req_t    [NI][2];
    int         ack_t    [NI][2];
    int         ack_cnt  [NI][2];
    bit         dir_req  [NI][2];
    bit         dir_we   [NI][2];
    logic [7:0] dir_a    [NI][2], dir_d [NI][2];
    bit         rnd_on;
    int         gq [$];

    function automatic logic [7:0] mem_init(input logic [7:0] a);
        if (a == 8'h3C) return 8'hA5;
        if (a == 8'hFF) return 8'hFF;
        return 8'(a * 8'd37 + 8'd11);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        simpleproc_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT($unsigned(g + 1))) dut (
            .clk(clk), .rst(rst),
            .req0(req_s[g][0]), .we0(we_s[g][0]), .addr0(addr_s[g][0]), .wdata0(wdat_s[g][0]),
            .rdata0(rd[g][0]), .ack0(ak[g][0]),
            .req1(req_s[g][1]), .we1(we_s[g][1]), .addr1(addr_s[g][1]), .wdata1(wdat_s[g][1]),
            .rdata1(rd[g][1]), .ack1(ak[g][1]),
            .mem_en(men[g]), .mem_we(mwe[g]), .mem_addr(madr[g]), .mem_wdata(mwd[g]),
            .mem_rdata(mrd[g]), .busy(bsy[g]), .grant_id(gid[g])
        );

        // Memory: data valid only in the cycle exactly MEM_LAT after mem_en
        logic [7:0] mem [256];
        logic [2:0] dcnt = '0;
        logic [7:0] dq = '0;
        initial for (int a = 0; a < 256; a++) mem[a] = mem_init(8'(a));
        always @(posedge clk) begin
            if (men[g]) begin
                dq   <= mem[madr[g]];
                dcnt <= 3'(g + 1);
                if (mwe[g]) mem[madr[g]] = mwd[g];
            end else if (dcnt != 3'd0) begin
                dcnt <= dcnt - 3'd1;
            end
        end
        assign mrd[g] = (dcnt == 3'd1) ? dq : ~dq;

        // Requests must be held until their ack
        for (genvar p = 0; p < 2; p++) begin : g_proto
            assert property (@(posedge clk) disable iff (rst) $fell(req_s[g][p]) |-> ak[g][p])
            else check($sformatf("L%0d_req%0d_held_to_ack", g + 1, p), 32'($sampled(ak[g][p])), 32'd1);
        end
    end

    task automatic check_outs(input int i, input bit e_en, e_bsy, e_ak0, e_ak1, e_gid, e_we,
                              input logic [7:0] e_a, e_d, e_r0, e_r1);
        string s;
        s = $sformatf("L%0d_", i + 1);
        check({s, "mem_en"},    32'(men[i]),   32'(e_en));
        check({s, "busy"},      32'(bsy[i]),   32'(e_bsy));
        check({s, "ack0"},      32'(ak[i][0]), 32'(e_ak0));
        check({s, "ack1"},      32'(ak[i][1]), 32'(e_ak1));
        check({s, "grant_id"},  32'(gid[i]),   32'(e_gid));
        check({s, "mem_we"},    32'(mwe[i]),   32'(e_we));
        check({s, "mem_addr"},  32'(madr[i]),  32'(e_a));
        check({s, "mem_wdata"}, 32'(mwd[i]),   32'(e_d));
        check({s, "rdata0"},    32'(rd[i][0]), 32'(e_r0));
        check({s, "rdata1"},    32'(rd[i][1]), 32'(e_r1));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            last_m[i] = 1'b1; free_at[i] = 0; have_cur[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                exp_rd[i][p] = 8'h00; pend[i][p] = 1'b0; dir_req[i][p] = 1'b0;
                req_s[i][p] = 1'b0; we_s[i][p] = 1'b0; addr_s[i][p] = 8'h00; wdat_s[i][p] = 8'h00;
            end
        end
    endtask

    task automatic start_req(input int i, input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
        pend[i][p] = 1'b1; req_s[i][p] = 1'b1;
        we_s[i][p] = w; addr_s[i][p] = a; wdat_s[i][p] = d;
        req_t[i][p] = t;
    endtask

    task automatic dir(input int i, input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
        dir_req[i][p] = 1'b1; dir_we[i][p] = w; dir_a[i][p] = a; dir_d[i][p] = d;
    endtask

    // One cycle of the bench, run at the falling edge: check, react, arbitrate
    task automatic step();
        int L, g;
        bit w, e_en, e_bsy, e_ak0, e_ak1, e_gid, e_we;
        logic [7:0] e_a, e_d;
        for (int i = 0; i < NI; i++) begin
            L = i + 1;
            if (i == 0 && men[i] === 1'b1) gq.push_back(int'(gid[i]));
            for (int p = 0; p < 2; p++)
                if (ak[i][p] === 1'b1) begin ack_t[i][p] = t; ack_cnt[i][p]++; end
            if (rst) begin
                check_outs(i, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
            end else begin
                e_en = 0; e_bsy = 0; e_ak0 = 0; e_ak1 = 0; e_gid = 0; e_we = 0;
                e_a = 8'h00; e_d = 8'h00;
                if (have_cur[i]) begin
                    g     = cur_g[i];
                    e_en  = (t == g + 1);
                    e_bsy = (t >= g + 1) && (t <= g + 2 + L);
                    e_gid = cur_p[i]; e_we = cur_we[i]; e_a = cur_a[i]; e_d = cur_d[i];
                    if (t == g + 2 + L) begin
                        if (cur_p[i]) e_ak1 = 1; else e_ak0 = 1;
                        if (!cur_we[i]) exp_rd[i][cur_p[i]] = cur_rv[i];
                    end
                end
                check_outs(i, e_en, e_bsy, e_ak0, e_ak1, e_gid, e_we, e_a, e_d, exp_rd[i][0], exp_rd[i][1]);
                for (int p = 0; p < 2; p++) begin
                    if (have_cur[i] && int'(cur_p[i]) == p && t == cur_g[i] + 2 + L) begin
                        pend[i][p] = 1'b0; req_s[i][p] = 1'b0;
                    end
                    if (!pend[i][p]) begin
                        if (dir_req[i][p])
                            start_req(i, p, dir_we[i][p], dir_a[i][p], dir_d[i][p]);
                        else if (rnd_on && $urandom_range(0, 3) == 0)
                            start_req(i, p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                    end
                    dir_req[i][p] = 1'b0;
                end
                if (t >= free_at[i] && (req_s[i][0] || req_s[i][1])) begin
                    if (req_s[i][0] && req_s[i][1]) w = !last_m[i];
                    else                            w = req_s[i][1];
                    have_cur[i] = 1'b1; cur_g[i] = t; cur_p[i] = w;
                    cur_we[i] = we_s[i][w]; cur_a[i] = addr_s[i][w]; cur_d[i] = wdat_s[i][w];
                    if (cur_we[i]) ref_mem[i][cur_a[i]] = cur_d[i];
                    else           cur_rv[i] = ref_mem[i][cur_a[i]];
                    last_m[i] = w; free_at[i] = t + 3 + L;
                end
            end
        end
        t++;
    endtask

    task automatic cyc();
        @(negedge clk);
        step();
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (pend[0][0] || pend[0][1] || pend[1][0] || pend[1][1] ||
                                    pend[2][0] || pend[2][1] || pend[3][0] || pend[3][1]); k++)
            cyc();
        repeat (4) cyc();
    endtask

    initial begin
        int t0, c0;
        rst = 1'b0; rnd_on = 1'b0;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 256; a++) ref_mem[i][a] = mem_init(8'(a));
            for (int p = 0; p < 2; p++) begin ack_t[i][p] = -1; ack_cnt[i][p] = 0; req_t[i][p] = 0; end
        end
        #1 rst = 1'b1;

        // Reset then idle
        repeat (3) cyc();
        rst = 1'b0;
        repeat (10) cyc();

        // Single read from the core
        dir(0, 0, 1'b0, 8'h3C, 8'h00); cyc(); t0 = req_t[0][0];
        repeat (6) cyc();
        check("rd_ack_latency", 32'(ack_t[0][0] - t0), 32'd3);
        check("rd_data", 32'(rd[0][0]), 32'hA5);

        // Write from the loader
        c0 = ack_cnt[0][1];
        dir(0, 1, 1'b1, 8'h10, 8'h5A); cyc(); t0 = req_t[0][1];
        repeat (6) cyc();
        check("wr_ack_latency", 32'(ack_t[0][1] - t0), 32'd3);
        check("wr_ack_pulses", 32'(ack_cnt[0][1] - c0), 32'd1);
        check("wr_rdata1_kept", 32'(rd[0][1]), 32'h00);
        check("wr_mem_content", 32'(g_inst[0].mem[8'h10]), 32'h5A);

        // Contention: both ports held
        gq.delete();
        for (int k = 0; k < 200 && gq.size() < 4; k++) begin
            dir(0, 0, 1'b0, 8'(k), 8'h00);
            dir(0, 1, 1'b0, 8'(k + 100), 8'h00);
            cyc();
        end
        drain();
        check("cont_grants", 32'(gq.size() >= 4), 32'd1);
        for (int j = 0; j < 4 && j < gq.size(); j++)
            check($sformatf("cont_order%0d", j), 32'(gq[j]), 32'(j % 2));

        // Latency sweep on all instances
        for (int i = 0; i < NI; i++) dir(i, 0, 1'b0, 8'hFF, 8'h00);
        cyc();
        repeat (10) cyc();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("L%0d_sweep_latency", i + 1), 32'(ack_t[i][0] - req_t[i][0]), 32'(2 + i + 1));
            check($sformatf("L%0d_sweep_data", i + 1), 32'(rd[i][0]), 32'hFF);
        end

        // Randomized traffic
        rnd_on = 1'b1;
        repeat (800) cyc();
        rnd_on = 1'b0;
        drain();

        // Reset in the WAIT cycle of a loader read
        c0 = ack_cnt[0][1];
        dir(0, 1, 1'b0, 8'h20, 8'h00); cyc();
        cyc(); cyc();
        rst = 1'b1;
        #1;
        check_outs(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        model_reset();
        repeat (3) cyc();
        rst = 1'b0;
        repeat (5) cyc();
        check("abort_no_ack1", 32'(ack_cnt[0][1] - c0), 32'd0);
        gq.delete();
        for (int k = 0; k < 100 && gq.size() < 2; k++) begin
            if (k == 0) begin
                dir(0, 0, 1'b0, 8'h3C, 8'h00);
                dir(0, 1, 1'b0, 8'h21, 8'h00);
            end
            cyc();
        end
        drain();
        check("post_rst_grants", 32'(gq.size()), 32'd2);
        if (gq.size() >= 2) begin
            check("post_rst_first", 32'(gq[0]), 32'd0);
            check("post_rst_second", 32'(gq[1]), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/simpleproc_mem_arbiter.md
# simpleproc_mem_arbiter

Two-port arbiter that shares the single-port program/data memory between the `simpleproc` core (port 0) and the memory loader/debug port (port 1). It grants one requester at a time using round-robin priority and drives the memory command. It waits a fixed memory latency, captures read data, and returns a one-cycle acknowledge to the granted requester. It sits between `simpleproc`'s address/datain/dataout bus and the memory macro.

## Interface
Parameters:
- `AW`, 8, address width.
- `DW`, 8, data width.
- `MEM_LAT`, 1, cycles from the `mem_en` cycle to the cycle in which `mem_rdata` is valid. Legal range is 1..4.

Ports:
- `clk`  in  1  single clock; all logic samples on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  port 0 (core) request. Held high until `ack0`.
- `we0`  in  1  port 0 write enable (1 = write, 0 = read). Stable while `req0` is high.
- `addr0`  in  AW  port 0 address. Stable while `req0` is high.
- `wdata0`  in  DW  port 0 write data. Stable while `req0` is high.
- `rdata0`  out  DW  port 0 read data. Valid when `ack0` is high; holds until the next port 0 read ack.
- `ack0`  out  1  port 0 completion pulse, one cycle wide.
- `req1`, `we1`, `addr1`, `wdata1`, `rdata1`, `ack1`: identical set for port 1 (loader).
- `mem_en`  out  1  memory access strobe, one cycle wide.
- `mem_we`  out  1  memory write enable. Qualified by `mem_en`.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data. Valid `MEM_LAT` cycles after `mem_en`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `grant_id`  out  1  currently or last granted port.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select the winner, latch its `we`/`addr`/`wdata` and the port index into the command register, then go to ISSUE.
- Arbitration is round-robin on `last`, the last served port:
  - If only one port requests, that port wins.
  - If both request, the port not equal to `last` wins.
  - `last` updates on grant.
- ISSUE (one cycle):
  - `mem_en`=1; `mem_we`/`mem_addr`/`mem_wdata` come from the command register.
  - Load `cnt` with `MEM_LAT`-1, then go to WAIT.
- WAIT:
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0, capture `mem_rdata` into `rdata[grant_id]` (reads only; writes leave `rdata` unchanged), then go to DONE.
- DONE (one cycle):
  - `ack[grant_id]`=1, then go to IDLE unconditionally.
  - Requests are not evaluated in DONE. This lets the requester drop `req` on the edge that ends the ack.
- `mem_addr`, `mem_we` and `mem_wdata` hold the command register value in every state. `mem_en` is high only in ISSUE.
- A request that deasserts before its ack is a protocol violation; the behaviour is unspecified, and a bench assertion flags it.

## Timing
- Reset values (asynchronous): state=IDLE, `last`=1 (so port 0 wins the first tie), `cnt`=0, `grant_id`=0, and `ack0`/`ack1`/`mem_en`/`mem_we`/`busy` all 0. `mem_addr`, `mem_wdata`, `rdata0` and `rdata1` are all zeros.
- All outputs are registered or decoded from registered state. There is no combinational path from `req*` to any output.
- Latency: if `req` is first high in IDLE at cycle T:
  - ISSUE is at T+1.
  - `mem_rdata` is sampled at T+1+`MEM_LAT`.
  - `ack` is high at T+2+`MEM_LAT`.
  - With `MEM_LAT`=1, `ack` is high at T+3.
- Back-to-back: the next grant is evaluated in IDLE at T+3+`MEM_LAT`. Peak throughput is one access per `MEM_LAT`+3 cycles.
- Simultaneous requests at reset: port 0 is served first, port 1 next, then alternation continues while both stay high.
- Reset mid-operation: the access is aborted immediately. `mem_en` and `ack` drop asynchronously, no ack is issued for the aborted access, and `rdata` is cleared.
- `busy` is high from ISSUE through DONE inclusive.

## Test plan
- Reset then idle: assert `rst` for 3 cycles, with no requests for 10 cycles after release -> every output stays at its reset value and `mem_en` is never asserted.
- Single read, `MEM_LAT`=1: `req0`=1, `we0`=0, `addr0`=8'h3C; the model returns 8'hA5 -> `mem_en` 1 cycle later with `mem_addr`=8'h3C and `mem_we`=0, `ack0` 3 cycles after the request, and `rdata0`=8'hA5.
- Write from loader: `req1`=1, `we1`=1, `addr1`=8'h10, `wdata1`=8'h5A -> `mem_en`/`mem_we`=1 with `mem_wdata`=8'h5A; `ack1` pulses once and `rdata1` is unchanged.
- Contention: `req0` and `req1` both held for 4 accesses -> grant order 0,1,0,1; each ack is exactly 1 cycle; no ack ever goes to an idle port.
- Latency sweep: `MEM_LAT`=1..4, read of 8'hFF at 8'hFF -> `ack0` at T+2+`MEM_LAT` and `rdata0`=8'hFF.
- Reset mid-access: assert `rst` in the WAIT cycle of a port 1 read -> no `ack1`, all outputs return to reset values, and a `req0` issued after release is served first.
